dmem_responder: RTL and testbench

//  Data-memory responder on the core's load/store port: accepts one word request at a time

---
 rtl/dmem_responder_pkg.sv | 15 +
 rtl/dmem_array.sv | 34 +++
 rtl/dmem_responder.sv | 145 ++++++++++++++
 tb/tb_dmem_responder.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// No logic; state encoding, word width and byte-lane count only.
// Imported by dmem_responder and dmem_array.
package dmem_responder_pkg;

    localparam int DMEM_DATA_W = 32;
    localparam int NUM_LANES   = DMEM_DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_array.sv
// Word storage with a byte-lane synchronous write port and a combinational read port.
// Latency: write lands on the clock edge, read is same-cycle.
// Backpressure: none; the caller qualifies we_i.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int DEPTH  = 32,
    parameter int IDX_W  = 5
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [NUM_LANES-1:0] be_i,
    input  logic [IDX_W-1:0]     idx_i,
    input  logic [DATA_W-1:0]    wdata_i,
    output logic [DATA_W-1:0]    rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (be_i[i]) begin
                    mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: one request at a time, access after WAIT_CYCLES, then a held response.
// Latency: response visible WAIT_CYCLES+1 cycles after the accept cycle.
// Backpressure: rsp_ready low freezes RESP; req_ready is low outside IDLE.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DATA_W      = DMEM_DATA_W,
    parameter int DEPTH       = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [31:0]          req_addr,
    input  logic [NUM_LANES-1:0] req_be,
    input  logic [DATA_W-1:0]    req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic                 rsp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic [31:0]          addr_q, addr_d;
    logic [NUM_LANES-1:0] be_q, be_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 err_q, err_d;

    logic                 do_access;
    logic                 acc_we;
    logic [31:0]          acc_addr;
    logic [NUM_LANES-1:0] acc_be;
    logic [DATA_W-1:0]    acc_wdata;
    logic [IDX_W-1:0]     acc_idx;
    logic                 acc_err;
    logic [DATA_W-1:0]    mem_rdata;

    // With WAIT_CYCLES=0 the access happens on the accept edge, so it must use the live inputs.
    assign acc_we    = (state_q == ST_IDLE) ? req_we    : we_q;
    assign acc_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
    assign acc_be    = (state_q == ST_IDLE) ? req_be    : be_q;
    assign acc_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
    assign acc_idx   = acc_addr[IDX_W+1:2];
    assign acc_err   = ((acc_addr >> (IDX_W + 2)) != 32'd0)
                    || ({{(32-IDX_W){1'b0}}, acc_idx} >= 32'(DEPTH));

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .we_i    (do_access && acc_we && !acc_err),
        .be_i    (acc_be),
        .idx_i   (acc_idx),
        .wdata_i (acc_wdata),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        do_access = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    be_d    = req_be;
                    wdata_d = req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d   = ST_RESP;
                        do_access = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d   = ST_RESP;
                    do_access = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (do_access) begin
            err_d   = acc_err;
            rdata_d = (acc_we || acc_err) ? '0 : mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances with WAIT_CYCLES 1, 0 and 3,
// expected responses queued at request time and compared when the response appears.
module tb_dmem_responder;

    localparam int ND = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [ND];
    logic        req_ready [ND];
    logic        req_we    [ND];
    logic [31:0] req_addr  [ND];
    logic [3:0]  req_be    [ND];
    logic [31:0] req_wdata [ND];
    logic        rsp_valid [ND];
    logic        rsp_ready [ND];
    logic [31:0] rsp_rdata [ND];
    logic        rsp_err   [ND];

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } txn_t;

    exp_t sb[$];

    function automatic int wait_of(input int d);
        case (d)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    for (genvar g = 0; g < ND; g++) begin : g_dut
        dmem_responder #(
            .DATA_W      (32),
            .DEPTH       (32),
            .WAIT_CYCLES ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_be    (req_be[g]),
            .req_wdata (req_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g])
        );
    end

    always #5 clk = ~clk;

    // Drives one request, queues its expected response, then scrambles the idle inputs.
    task automatic send(input int d, input txn_t t);
        exp_t e;
        @(negedge clk);
        req_we[d]    = t.we;
        req_addr[d]  = t.addr;
        req_be[d]    = t.be;
        req_wdata[d] = t.wdata;
        req_valid[d] = 1'b1;
        e.rdata = t.rdata;
        e.err   = t.err;
        e.lat   = wait_of(d) + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        req_we[d]    = 1'($urandom);
        req_addr[d]  = $urandom;
        req_be[d]    = 4'($urandom);
        req_wdata[d] = $urandom;
    endtask

    // Called right after send; lat=1 means rsp_valid was already up after the accept edge.
    task automatic recv(input int d, output logic [31:0] rd, output logic er, output int lat);
        lat = 1;
        while (rsp_valid[d] !== 1'b1 && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = rsp_rdata[d];
        er = rsp_err[d];
        if (rsp_ready[d] === 1'b1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            tests++;
            if ({req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_err[d]} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
                fails++;
                $display("FAIL reset_hold[%0d]: got rdy=%b vld=%b rdata=%h err=%b, want rdy=1 vld=0 rdata=0 err=0",
                         d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_err[d]);
            end
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            tests++;
            if ({req_ready[d], rsp_valid[d]} !== 2'b10) begin
                fails++;
                $display("FAIL reset_release[%0d]: got rdy=%b vld=%b, want rdy=1 vld=0", d, req_ready[d], rsp_valid[d]);
            end
        end
    endtask

    task automatic test_store_load();
        txn_t t [2];
        logic [31:0] rd;
        logic er;
        int lat;
        exp_t e;
        t[0] = '{1'b1, 32'h8, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0};
        t[1] = '{1'b0, 32'h8, 4'h3, 32'h0, 32'hDEADBEEF, 1'b0};
        foreach (t[i]) begin
            send(0, t[i]);
            recv(0, rd, er, lat);
            e = sb.pop_front();
            tests++;
            if ({rd, er, lat} !== {e.rdata, e.err, e.lat}) begin
                fails++;
                $display("FAIL store_load[%0d]: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
                         i, rd, er, lat, e.rdata, e.err, e.lat);
            end
        end
    endtask

    task automatic test_byte_lanes();
        txn_t t [2];
        logic [31:0] rd;
        logic er;
        int lat;
        exp_t e;
        t[0] = '{1'b1, 32'h8, 4'b0101, 32'h11223344, 32'h0, 1'b0};
        t[1] = '{1'b0, 32'h8, 4'h0, 32'h0, 32'hDE22BE44, 1'b0};
        foreach (t[i]) begin
            send(0, t[i]);
            recv(0, rd, er, lat);
            e = sb.pop_front();
            tests++;
            if ({rd, er, lat} !== {e.rdata, e.err, e.lat}) begin
                fails++;
                $display("FAIL byte_lanes[%0d]: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
                         i, rd, er, lat, e.rdata, e.err, e.lat);
            end
        end
    endtask

    task automatic test_back_pressure();
        txn_t t;
        logic [31:0] rd;
        logic er;
        int lat;
        exp_t e;
        logic seen;
        rsp_ready[0] = 1'b0;
        t = '{1'b0, 32'h8, 4'hF, 32'h0, 32'hDE22BE44, 1'b0};
        send(0, t);
        recv(0, rd, er, lat);
        e = sb.pop_front();
        tests++;
        if ({rd, er, lat} !== {e.rdata, e.err, e.lat}) begin
            fails++;
            $display("FAIL bp_first: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
                     rd, er, lat, e.rdata, e.err, e.lat);
        end
        // A competing store is held on the request port the whole time; it must never be taken.
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h8;
        req_be[0]    = 4'hF;
        req_wdata[0] = 32'h0;
        req_valid[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            tests++;
            if ({rsp_valid[0], rsp_rdata[0], rsp_err[0], req_ready[0]} !== {1'b1, e.rdata, e.err, 1'b0}) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got vld=%b rdata=%h err=%b rdy=%b, want vld=1 rdata=%h err=%b rdy=0",
                         c, rsp_valid[0], rsp_rdata[0], rsp_err[0], req_ready[0], e.rdata, e.err);
            end
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        tests++;
        if ({rsp_valid[0], req_ready[0]} !== 2'b01) begin
            fails++;
            $display("FAIL bp_release: got vld=%b rdy=%b, want vld=0 rdy=1", rsp_valid[0], req_ready[0]);
        end
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (rsp_valid[0] !== 1'b0) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL bp_no_accept: got a response from a request offered in RESP, want none");
        end
        t = '{1'b0, 32'h8, 4'h0, 32'h0, 32'hDE22BE44, 1'b0};
        send(0, t);
        recv(0, rd, er, lat);
        e = sb.pop_front();
        tests++;
        if ({rd, er, lat} !== {e.rdata, e.err, e.lat}) begin
            fails++;
            $display("FAIL bp_after: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
                     rd, er, lat, e.rdata, e.err, e.lat);
        end
    endtask

    task automatic test_out_of_range();
        txn_t t [9];
        logic [31:0] rd;
        logic er;
        int lat;
        exp_t e;
        t[0] = '{1'b1, 32'h00000000, 4'hF, 32'h600DF00D, 32'h0, 1'b0};
        t[1] = '{1'b1, 32'h0000007C, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0};
        t[2] = '{1'b1, 32'h00000080, 4'hF, 32'h55555555, 32'h0, 1'b1};
        t[3] = '{1'b1, 32'h80000000, 4'hF, 32'h77777777, 32'h0, 1'b1};
        t[4] = '{1'b1, 32'h0000007C, 4'h0, 32'hFFFFFFFF, 32'h0, 1'b0};
        t[5] = '{1'b0, 32'h00000080, 4'hF, 32'h0, 32'h0, 1'b1};
        t[6] = '{1'b0, 32'h0000007C, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0};
        t[7] = '{1'b0, 32'h00000000, 4'hF, 32'h0, 32'h600DF00D, 1'b0};
        t[8] = '{1'b0, 32'h0000007E, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0};
        foreach (t[i]) begin
            send(0, t[i]);
            recv(0, rd, er, lat);
            e = sb.pop_front();
            tests++;
            if ({rd, er, lat} !== {e.rdata, e.err, e.lat}) begin
                fails++;
                $display("FAIL out_of_range[%0d]: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
                         i, rd, er, lat, e.rdata, e.err, e.lat);
            end
        end
    endtask

    task automatic test_wait0();
        txn_t t [3];
        logic [31:0] rd;
        logic er;
        int lat;
        exp_t e;
        t[0] = '{1'b1, 32'h4, 4'hF, 32'h0BADF00D, 32'h0, 1'b0};
        t[1] = '{1'b1, 32'h4, 4'b1000, 32'hAA000000, 32'h0, 1'b0};
        t[2] = '{1'b0, 32'h4, 4'h0, 32'h0, 32'hAAADF00D, 1'b0};
        foreach (t[i]) begin
            send(1, t[i]);
            recv(1, rd, er, lat);
            e = sb.pop_front();
            tests++;
            if ({rd, er, lat} !== {e.rdata, e.err, e.lat}) begin
                fails++;
                $display("FAIL wait0[%0d]: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
                         i, rd, er, lat, e.rdata, e.err, e.lat);
            end
        end
    endtask

    task automatic test_midop_reset();
        txn_t t [3];
        logic [31:0] rd;
        logic er;
        int lat;
        exp_t e;
        t[0] = '{1'b1, 32'h10, 4'hF, 32'hA5A55A5A, 32'h0, 1'b0};
        t[1] = '{1'b0, 32'h10, 4'h0, 32'h0, 32'hA5A55A5A, 1'b0};
        t[2] = '{1'b0, 32'h10, 4'h0, 32'h0, 32'hA5A55A5A, 1'b0};
        for (int i = 0; i < 2; i++) begin
            send(2, t[i]);
            recv(2, rd, er, lat);
            e = sb.pop_front();
            tests++;
            if ({rd, er, lat} !== {e.rdata, e.err, e.lat}) begin
                fails++;
                $display("FAIL midop_setup[%0d]: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
                         i, rd, er, lat, e.rdata, e.err, e.lat);
            end
        end
        @(negedge clk);
        req_we[2]    = 1'b1;
        req_addr[2]  = 32'h10;
        req_be[2]    = 4'hF;
        req_wdata[2] = 32'h12345678;
        req_valid[2] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        @(negedge clk);
        tests++;
        if ({req_ready[2], rsp_valid[2]} !== 2'b00) begin
            fails++;
            $display("FAIL midop_in_wait: got rdy=%b vld=%b, want rdy=0 vld=0", req_ready[2], rsp_valid[2]);
        end
        rst = 1'b0;
        #1;
        tests++;
        if ({req_ready[2], rsp_valid[2], rsp_rdata[2], rsp_err[2]} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            fails++;
            $display("FAIL midop_reset: got rdy=%b vld=%b rdata=%h err=%b, want rdy=1 vld=0 rdata=0 err=0",
                     req_ready[2], rsp_valid[2], rsp_rdata[2], rsp_err[2]);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        send(2, t[2]);
        recv(2, rd, er, lat);
        e = sb.pop_front();
        tests++;
        if ({rd, er, lat} !== {e.rdata, e.err, e.lat}) begin
            fails++;
            $display("FAIL midop_unchanged: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
                     rd, er, lat, e.rdata, e.err, e.lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        for (int d = 0; d < ND; d++) begin
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = 32'h0;
            req_be[d]    = 4'h0;
            req_wdata[d] = 32'h0;
            rsp_ready[d] = 1'b1;
        end
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_back_pressure();
        test_out_of_range();
        test_wait0();
        test_midop_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
